// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial two's-complement subtractor with start/busy/done handshake
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t         state, state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             borrow;
    logic [CW-1:0]    cnt;
    logic             ai, bi, d, bo, last;

    assign ai   = a_sr[0];
    assign bi   = b_sr[0];
    assign d    = ai ^ bi ^ borrow;
    assign bo   = (~ai & bi) | (~(ai ^ bi) & borrow);
    assign last = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == SHIFT) || (state == DONE);
        done = (state == DONE);
    end

    // Difference bits are shifted into the vacated top of a_sr, so a_sr doubles
    // as the internal result register; on the last bit a_sr[0] is still the
    // captured minuend MSB, which is what the overflow term needs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            bout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr   <= a;
                        b_sr   <= b;
                        borrow <= 1'b0;
                        cnt    <= '0;
                    end
                end
                SHIFT: begin
                    a_sr   <= {d, a_sr[WIDTH-1:1]};
                    b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
                    borrow <= bo;
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        diff <= {d, a_sr[WIDTH-1:1]};
                        bout <= bo;
                        ovf  <= (ai != bi) && (d != ai);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - randomized self-checking bench for serial_subtractor
module tb_serial_subtractor;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a, b;
    logic         busy, done, bout, ovf;
    logic [W-1:0] diff;

    int tests = 0;
    int failed = 0;
    logic [W-1:0] prev_diff;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .diff(diff), .bout(bout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int sval(input logic [W-1:0] v);
        return v[W-1] ? int'(v) - (1 << W) : int'(v);
    endfunction

    // Called on a negedge with the DUT idle; returns on a negedge with the DUT idle again.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input bit mid_start,
                          input int rst_at);
        int lat;
        bit busy_ok, stable_ok, aborted;
        int s;
        logic [W-1:0] ed;
        ed = ta - tb_;
        s = sval(ta) - sval(tb_);
        a = ta; b = tb_; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom);
        lat = 0; busy_ok = 1; stable_ok = 1; aborted = 0;
        while (!done && lat < 3 * W) begin
            if (!busy) busy_ok = 0;
            if (diff !== prev_diff) stable_ok = 0;
            if (mid_start && lat == 3) begin start = 1'b1; a = 8'hFF; b = 8'h01; end
            if (mid_start && lat == 4) start = 1'b0;
            if (lat == rst_at) begin
                #2 rst = 1'b1;
                #1;
                check("rst_busy", busy, 0);
                check("rst_done", done, 0);
                check("rst_diff", diff, 0);
                check("rst_bout", bout, 0);
                check("rst_ovf", ovf, 0);
                aborted = 1;
                prev_diff = '0;
                break;
            end
            @(negedge clk);
            lat++;
        end
        if (aborted) begin
            int seen = 0;
            repeat (3) begin
                @(negedge clk);
                if (done) seen++;
            end
            rst = 1'b0;
            repeat (W + 3) begin
                @(negedge clk);
                if (done || busy) seen++;
            end
            check("rst_no_done", seen, 0);
            return;
        end
        check("latency", lat, W);
        check("busy_hold", busy_ok, 1);
        check("diff_stable", stable_ok, 1);
        check("busy_at_done", busy, 1);
        check("diff", diff, ed);
        check("bout", bout, (ta < tb_) ? 1 : 0);
        check("ovf", ovf, (s > (1 << (W - 1)) - 1 || s < -(1 << (W - 1))) ? 1 : 0);
        prev_diff = ed;
        @(negedge clk);
        check("done_pulse", done, 0);
        check("idle_after", busy, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        prev_diff = '0;
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_diff", diff, 0);
        check("reset_bout", bout, 0);
        check("reset_ovf", ovf, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_op(8'h09, 8'h03, 0, -1);
        run_op(8'h03, 8'h09, 0, -1);
        run_op(8'h00, 8'h00, 0, -1);
        run_op(8'h80, 8'h01, 0, -1);
        run_op(8'h7F, 8'hFF, 0, -1);
        run_op(8'h5A, 8'h5A, 0, -1);
        run_op(8'h09, 8'h03, 1, -1);
        run_op(8'h09, 8'h03, 0, 3);
        run_op(8'h80, 8'h7F, 0, -1);

        for (int i = 0; i < 1000; i++) begin
            run_op(W'($urandom), W'($urandom), 0, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
